// File: rtl/frame_rx.sv
// frame_rx: GMII receive framer; strips preamble/SFD/FCS, streams payload to the MAC
// and checks the trailing FCS against an external CRC32 core.
module frame_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_rxdv,
  input  logic [7:0]  eth_rxd,
  output logic [7:0]  mac_rxd,
  output logic        mac_rxen,
  output logic        crc_clr,
  output logic        crc_en,
  input  logic [31:0] crc,
  output logic        fd,
  input  logic        fd_ack,
  output logic        crc_ok,
  output logic [10:0] len,
  output logic        eth_rxrdy
);
  typedef enum logic [2:0] {IDLE, WAIT, PRE, WORK, CHK0, CHK1, DONE, DROP} state_t;
  state_t state, state_nx;
  logic [2:0] pcnt, fill;
  logic [31:0] dl;
  logic sfd, push, full;
  assign sfd = state == PRE && eth_rxdv && eth_rxd == 8'hD5 && pcnt >= 3'd2;
  assign push = state == WORK && eth_rxdv;
  assign full = fill == 3'd4;
  assign fd = state == DONE;
  assign eth_rxrdy = state == WAIT;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = WAIT;
      WAIT: state_nx = eth_rxdv ? PRE : WAIT;
      PRE:  state_nx = !eth_rxdv ? WAIT : eth_rxd == 8'h55 ? PRE : sfd ? WORK : DROP;
      WORK: state_nx = eth_rxdv ? WORK : full ? CHK0 : CHK1;
      CHK0: state_nx = CHK1;
      CHK1: state_nx = DONE;
      DONE: state_nx = fd_ack ? WAIT : DONE;
      DROP: state_nx = eth_rxdv ? DROP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // The last four bytes in the delay line are the FCS; a runt never fills it, so it can never match.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt <= '0;
      fill <= '0;
      dl <= '0;
      mac_rxd <= '0;
      mac_rxen <= 1'b0;
      crc_clr <= 1'b0;
      crc_en <= 1'b0;
      crc_ok <= 1'b0;
      len <= '0;
    end else begin
      pcnt <= state == WAIT ? 3'd0 :
              (state == PRE && eth_rxdv && eth_rxd == 8'h55 && pcnt != 3'd7) ? pcnt + 3'd1 : pcnt;
      crc_clr <= sfd;
      mac_rxen <= push && full;
      crc_en <= push && full;
      if (sfd) begin
        dl <= '0;
        fill <= '0;
        len <= '0;
        crc_ok <= 1'b0;
      end
      if (push) begin
        dl <= {dl[23:0], eth_rxd};
        fill <= full ? fill : fill + 3'd1;
      end
      if (push && full) begin
        mac_rxd <= dl[31:24];
        len <= len + 11'(len != 11'h7FF);
      end
      if (state == CHK1) crc_ok <= full && crc == dl;
    end
endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: directed and random frames against a frame-level model plus a CRC32 core model.
module tb_frame_rx;
  typedef logic [7:0] bq_t [$];
  logic clk = 0, rst = 1, eth_rxdv = 0, fd_ack = 0;
  logic [7:0] eth_rxd = 0;
  logic [7:0] mac_rxd;
  logic mac_rxen, crc_clr, crc_en, fd, crc_ok, eth_rxrdy;
  logic [10:0] len;
  logic [31:0] crc;
  logic [31:0] c_reg = '1;
  bq_t got;
  int n_clr = 0;
  int checks = 0, errors = 0;

  frame_rx dut (.clk(clk), .rst(rst), .eth_rxdv(eth_rxdv), .eth_rxd(eth_rxd), .mac_rxd(mac_rxd),
    .mac_rxen(mac_rxen), .crc_clr(crc_clr), .crc_en(crc_en), .crc(crc), .fd(fd), .fd_ack(fd_ack),
    .crc_ok(crc_ok), .len(len), .eth_rxrdy(eth_rxrdy));

  always #5 clk = ~clk;

  function automatic logic [31:0] upd(logic [31:0] c, logic [7:0] b);
    c = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  function automatic logic [31:0] fcs_of(bq_t p);
    logic [31:0] c = '1;
    foreach (p[i]) c = upd(c, p[i]);
    return ~c;
  endfunction

  // External CRC32 core: result visible one clock after each enabled byte.
  assign crc = ~c_reg;
  always @(posedge clk)
    if (crc_clr) c_reg <= '1;
    else if (crc_en) c_reg <= upd(c_reg, mac_rxd);

  always @(negedge clk) begin
    if (mac_rxen) got.push_back(mac_rxd);
    if (crc_clr) n_clr <= n_clr + 1;
  end

  function automatic bq_t frame(int npre, bq_t p, logic [31:0] xm);
    bq_t q;
    logic [31:0] f = fcs_of(p) ^ xm;
    repeat (npre) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (p[i]) q.push_back(p[i]);
    for (int i = 3; i >= 0; i--) q.push_back(f[8*i +: 8]);
    return q;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(bq_t q);
    foreach (q[i]) begin
      @(negedge clk);
      eth_rxdv = 1;
      eth_rxd = q[i];
    end
    @(negedge clk);
    eth_rxdv = 0;
    eth_rxd = 0;
  endtask

  task automatic expect_frame(string t, bq_t p, logic ok, int base, bit ack);
    int i = 0;
    while (!fd && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk({t, ".fd"}, 32'(fd), 1);
    chk({t, ".len"}, 32'(len), 32'(p.size()));
    chk({t, ".crc_ok"}, 32'(crc_ok), 32'(ok));
    chk({t, ".nbytes"}, 32'(got.size() - base), 32'(p.size()));
    for (int j = 0; j < p.size() && base + j < got.size(); j++)
      chk({t, ".byte"}, 32'(got[base + j]), 32'(p[j]));
    chk({t, ".rxrdy_busy"}, 32'(eth_rxrdy), 0);
    if (ack) begin
      @(negedge clk);
      fd_ack = 1;
      @(negedge clk);
      fd_ack = 0;
      chk({t, ".fd_clr"}, 32'(fd), 0);
      chk({t, ".rxrdy"}, 32'(eth_rxrdy), 1);
    end
  endtask

  initial begin
    bq_t p6, bad, none, q;
    int base, clr0;
    for (int i = 1; i <= 6; i++) p6.push_back(8'(i));
    // reset state
    repeat (2) @(negedge clk);
    chk("rst.mac_rxd", 32'(mac_rxd), 0);
    chk("rst.mac_rxen", 32'(mac_rxen), 0);
    chk("rst.crc_clr", 32'(crc_clr), 0);
    chk("rst.crc_en", 32'(crc_en), 0);
    chk("rst.fd", 32'(fd), 0);
    chk("rst.crc_ok", 32'(crc_ok), 0);
    chk("rst.len", 32'(len), 0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst.rxrdy", 32'(eth_rxrdy), 1);
    // good frame
    base = got.size();
    send(frame(7, p6, 0));
    expect_frame("good", p6, 1, base, 1);
    // last FCS byte flipped
    base = got.size();
    send(frame(7, p6, 32'hFF));
    expect_frame("badfcs", p6, 0, base, 1);
    // bad preamble
    base = got.size();
    clr0 = n_clr;
    bad = '{8'h55, 8'h55, 8'hA7, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(bad);
    repeat (20) @(negedge clk);
    chk("drop.fd", 32'(fd), 0);
    chk("drop.clr", 32'(n_clr - clr0), 0);
    chk("drop.nbytes", 32'(got.size() - base), 0);
    chk("drop.rxrdy", 32'(eth_rxrdy), 1);
    send(frame(7, p6, 0));
    expect_frame("after_drop", p6, 1, base, 1);
    // runt
    base = got.size();
    q = frame(7, none, 0);
    repeat (4) void'(q.pop_back());
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    send(q);
    expect_frame("runt", none, 0, base, 1);
    // frame arriving while fd is held is ignored
    base = got.size();
    send(frame(7, p6, 0));
    expect_frame("held", p6, 1, base, 0);
    send(frame(7, p6, 32'hFF));
    repeat (10) @(negedge clk);
    chk("held.nbytes", 32'(got.size() - base), 6);
    chk("held.crc_ok", 32'(crc_ok), 1);
    expect_frame("held2", p6, 1, base, 1);
    base = got.size();
    send(frame(7, p6, 0));
    expect_frame("third", p6, 1, base, 1);
    // async reset during payload byte 3
    base = got.size();
    q = frame(7, p6, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      eth_rxdv = 1;
      eth_rxd = q[i];
    end
    @(negedge clk);
    eth_rxd = q[10];
    #1 rst = 1;
    #1;
    chk("arst.mac_rxd", 32'(mac_rxd), 0);
    chk("arst.mac_rxen", 32'(mac_rxen), 0);
    chk("arst.crc_clr", 32'(crc_clr), 0);
    chk("arst.crc_en", 32'(crc_en), 0);
    chk("arst.fd", 32'(fd), 0);
    chk("arst.crc_ok", 32'(crc_ok), 0);
    chk("arst.len", 32'(len), 0);
    @(negedge clk);
    rst = 0;
    eth_rxdv = 0;
    repeat (5) @(negedge clk);
    chk("arst.nofd", 32'(fd), 0);
    chk("arst.nbytes", 32'(got.size() - base), 0);
    send(frame(7, p6, 0));
    expect_frame("arst_good", p6, 1, base, 1);
    // random frames
    for (int k = 0; k < 25; k++) begin
      bq_t p, exp_p;
      logic ok;
      int npre = $urandom_range(3, 7);
      int l = $urandom_range(0, 40);
      bit runt = $urandom_range(0, 5) == 0;
      bit corrupt = $urandom_range(0, 2) == 0;
      repeat (l) p.push_back(8'($urandom));
      base = got.size();
      if (runt) begin
        q = frame(npre, none, 0);
        repeat (4) void'(q.pop_back());
        repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
        ok = 0;
      end else begin
        q = frame(npre, p, corrupt ? 32'(1) << $urandom_range(0, 31) : 32'h0);
        exp_p = p;
        ok = !corrupt;
      end
      send(q);
      expect_frame("rand", exp_p, ok, base, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
